// File: rtl/ahb_lite_slave_if_if.sv
// ----------------------------------------------------------------------------
// ahb_lite_slave_if_if
//   AHB-Lite bus bundle between the ZYNQ master (plus the bus-level HREADY
//   return) and the ahb_lite_slave_if front end.
//
//   hsel       master -> slave  slave select from the AHB decoder
//   haddr      master -> slave  address, address phase
//   htrans     master -> slave  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   hwrite     master -> slave  1 = write, address phase
//   hsize      master -> slave  transfer size, address phase
//   hwdata     master -> slave  write data, data phase
//   hready     master -> slave  bus-level HREADY (interconnect return)
//   hreadyout  slave -> master  slave ready, 0 = wait state
//   hresp      slave -> master  0 OKAY, 1 ERROR
//   hrdata     slave -> master  registered read data
// ----------------------------------------------------------------------------
interface ahb_lite_slave_if_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_lite_slave_if.sv
// ----------------------------------------------------------------------------
// ahb_lite_slave_if
//   AHB-Lite slave front end feeding the ahb_ctrl address decoder. Turns
//   pipelined AHB-Lite transfers into the flat ahb_we / ahb_addr /
//   ahb_write_data / ahb_read_data interface. Writes complete with zero
//   wait states; reads take one wait state so the synchronous IM/DM/RF read
//   data can settle, and the read data is registered onto hrdata.
//
// Optional feature macro: AHB_ERR_RESP_EN
//   Defined   : illegal transfers (hsize != word, misaligned, or outside the
//               mapped window and not the CPU reset register) and ahb_resp
//               errors produce a two-cycle AHB ERROR response.
//   Undefined : every transfer is legal, haddr[1:0] is dropped, hresp stays 0
//               and ahb_resp is ignored.
//
// Ports
//   clk             in   1   system clock, posedge
//   rstn            in   1   asynchronous active-low reset
//   bus             slave modport of ahb_lite_slave_if_if (AHB-Lite side)
//   ahb_we          out  1   write strobe to ahb_ctrl
//   ahb_addr        out  32  word-aligned address to ahb_ctrl
//   ahb_write_data  out  32  write data to ahb_ctrl (hwdata pass-through)
//   ahb_read_data   in   32  read data from ahb_ctrl
//   ahb_ready       in   1   ahb_ctrl ready, 0 stalls the current data phase
//   ahb_resp        in   1   ahb_ctrl error flag
// ----------------------------------------------------------------------------
module ahb_lite_slave_if #(
    parameter logic [31:0] ZYNQ_BASE = 32'h4000_0000,
    parameter logic [31:0] MAP_TOP   = 32'h4000_407C,
    parameter logic [31:0] RSTN_ADDR = 32'h4000_8004
) (
    input  logic                      clk,
    input  logic                      rstn,
    ahb_lite_slave_if_if.slave        bus,
    output logic                      ahb_we,
    output logic [31:0]               ahb_addr,
    output logic [31:0]               ahb_write_data,
    input  logic [31:0]               ahb_read_data,
    input  logic                      ahb_ready,
    input  logic                      ahb_resp
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_RD_WAIT = 3'd2,
        S_RD_DONE = 3'd3,
        S_ERR1    = 3'd4,
        S_ERR2    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_ahb_addr;
    logic [31:0] r_hrdata;

    logic        w_accept;
    logic        w_illegal;
    logic        w_resp_err;
    logic        w_take;
    logic        w_addr_load;
    logic        w_rd_capture;
    logic        w_hreadyout;
    logic        w_hresp;
    logic        w_we;
    logic        w_unused;

    // BUSY and IDLE both have htrans[1] == 0, so they never count as a transfer.
    assign w_accept = bus.hsel & bus.hready & bus.htrans[1];

`ifdef AHB_ERR_RESP_EN
    function automatic logic f_illegal(input logic [31:0] addr, input logic [2:0] size);
        logic in_window;
        in_window = (addr >= ZYNQ_BASE) && (addr <= MAP_TOP);
        return (size != 3'b010) || (addr[1:0] != 2'b00) ||
               (!in_window && (addr != RSTN_ADDR));
    endfunction

    assign w_illegal  = f_illegal(bus.haddr, bus.hsize);
    assign w_resp_err = ahb_resp;
    assign w_unused   = bus.htrans[0];
`else
    assign w_illegal  = 1'b0;
    assign w_resp_err = 1'b0;
    assign w_unused   = ^{bus.htrans[0], bus.haddr[1:0], bus.hsize, ahb_resp,
                          ZYNQ_BASE, MAP_TOP, RSTN_ADDR};
`endif

    // Next-state and output decode. w_take marks the cycles in which the
    // current data phase ends, so a new address phase may be acted upon.
    always_comb begin
        w_state_nxt  = r_state;
        w_hreadyout  = 1'b1;
        w_hresp      = 1'b0;
        w_we         = 1'b0;
        w_take       = 1'b0;
        w_addr_load  = 1'b0;
        w_rd_capture = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_take = 1'b1;
            end
            S_WR: begin
                // Write commits on the edge that ends the data phase; an
                // ahb_ctrl error replaces the commit with an ERROR response.
                w_hreadyout = ahb_ready & ~w_resp_err;
                w_we        = ahb_ready & ~w_resp_err;
                if (ahb_ready) begin
                    if (w_resp_err) begin
                        w_state_nxt = S_ERR1;
                    end else begin
                        w_take = 1'b1;
                    end
                end
            end
            S_RD_WAIT: begin
                w_hreadyout = 1'b0;
                if (ahb_ready) begin
                    if (w_resp_err) begin
                        w_state_nxt = S_ERR1;
                    end else begin
                        w_rd_capture = 1'b1;
                        w_state_nxt  = S_RD_DONE;
                    end
                end
            end
            S_RD_DONE: begin
                w_take = 1'b1;
            end
            S_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = 1'b1;
                w_state_nxt = S_ERR2;
            end
            S_ERR2: begin
                w_hresp = 1'b1;
                w_take  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_take) begin
            if (w_accept) begin
                if (w_illegal) begin
                    w_state_nxt = S_ERR1;
                end else begin
                    w_addr_load = 1'b1;
                    w_state_nxt = bus.hwrite ? S_WR : S_RD_WAIT;
                end
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ahb_addr holds between transfers so ahb_ctrl's decode stays stable;
    // hrdata only changes on a read capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ahb_addr <= 32'h0;
            r_hrdata   <= 32'h0;
        end else begin
            if (w_addr_load) begin
                r_ahb_addr <= {bus.haddr[31:2], 2'b00};
            end
            if (w_rd_capture) begin
                r_hrdata <= ahb_read_data;
            end
        end
    end

    assign bus.hreadyout  = w_hreadyout;
    assign bus.hresp      = w_hresp;
    assign bus.hrdata     = r_hrdata;
    assign ahb_we         = w_we;
    assign ahb_addr       = r_ahb_addr;
    assign ahb_write_data = bus.hwdata;

endmodule

// File: tb/tb_ahb_lite_slave_if.sv
module tb_ahb_lite_slave_if;

`ifdef AHB_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [31:0] ADDR_TAB [0:9] = '{
        32'h4000_0000, 32'h4000_0004, 32'h4000_0008, 32'h4000_2004, 32'h4000_4004,
        32'h4000_407C, 32'h4000_8004, 32'h4000_6000, 32'h3FFF_FFFC, 32'h4000_0010
    };

    logic        clk;
    logic        rstn;
    logic        ahb_we;
    logic [31:0] ahb_addr;
    logic [31:0] ahb_write_data;
    logic [31:0] ahb_read_data;
    logic        ahb_ready;
    logic        ahb_resp;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    bit rand_ready = 1'b0;

    ahb_lite_slave_if_if bus ();
    assign bus.hready = bus.hreadyout;

    ahb_lite_slave_if dut (
        .clk            (clk),
        .rstn           (rstn),
        .bus            (bus),
        .ahb_we         (ahb_we),
        .ahb_addr       (ahb_addr),
        .ahb_write_data (ahb_write_data),
        .ahb_read_data  (ahb_read_data),
        .ahb_ready      (ahb_ready),
        .ahb_resp       (ahb_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ahb_ctrl stand-in: a plain word memory ----------------
    logic [31:0] ctrl_mem [logic [31:0]];
    always @(posedge clk) begin
        if (ahb_we === 1'b1) ctrl_mem[ahb_addr] = ahb_write_data;
    end
    always @(negedge clk) begin
        ahb_read_data = ctrl_mem.exists(ahb_addr) ? ctrl_mem[ahb_addr] : 32'h0;
    end

    // ---------------- reference model ----------------
    typedef enum {DP_NONE, DP_WR, DP_RD, DP_ER} dp_e;
    dp_e         dp_kind = DP_NONE;
    logic [31:0] dp_addr = 32'h0;
    bit          dp_cap  = 1'b0;
    int          dp_age  = 0;
    logic [31:0] exp_addr   = 32'h0;
    logic [31:0] exp_hrdata = 32'h0;
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic bit illegal(input logic [31:0] a, input logic [2:0] sz);
        return ERR_EN && ((sz != 3'b010) || (a[1:0] != 2'b00) ||
               (!((a >= 32'h4000_0000) && (a <= 32'h4000_407C)) && (a != 32'h4000_8004)));
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: the expected outputs follow from what the data phase
    // in flight is (none, write, read, error) and how far it has progressed.
    always @(negedge clk) begin
        bit e_hro, e_resp, e_we, rerr;
        logic [31:0] a;
        if (!rstn) begin
            dp_kind    = DP_NONE;
            dp_cap     = 1'b0;
            dp_age     = 0;
            exp_addr   = 32'h0;
            exp_hrdata = 32'h0;
        end else begin
            rerr   = ERR_EN && ahb_resp;
            e_hro  = 1'b1;
            e_resp = 1'b0;
            e_we   = 1'b0;
            case (dp_kind)
                DP_WR: begin e_hro = ahb_ready && !rerr; e_we = e_hro; end
                DP_RD: e_hro = dp_cap;
                DP_ER: begin e_hro = (dp_age == 1); e_resp = 1'b1; end
                default: ;
            endcase
            if (ahb_we === 1'b1) we_cnt++;
            chk1 ("m_hreadyout", bus.hreadyout, e_hro);
            chk1 ("m_hresp",     bus.hresp,     e_resp);
            chk1 ("m_ahb_we",    ahb_we,        e_we);
            chk32("m_ahb_addr",  ahb_addr,      exp_addr);
            chk32("m_hrdata",    bus.hrdata,    exp_hrdata);
            chk32("m_wdata",     ahb_write_data, bus.hwdata);

            if (e_hro) begin
                if (dp_kind == DP_WR) ref_mem[dp_addr] = bus.hwdata;
                if (bus.hsel && bus.htrans[1]) begin
                    a = {bus.haddr[31:2], 2'b00};
                    if (illegal(bus.haddr, bus.hsize)) begin
                        dp_kind = DP_ER;
                        dp_age  = 0;
                    end else begin
                        exp_addr = a;
                        dp_addr  = a;
                        dp_kind  = bus.hwrite ? DP_WR : DP_RD;
                        dp_cap   = 1'b0;
                    end
                end else begin
                    dp_kind = DP_NONE;
                end
            end else begin
                case (dp_kind)
                    DP_WR: if (ahb_ready && rerr) begin dp_kind = DP_ER; dp_age = 0; end
                    DP_RD: if (ahb_ready) begin
                        if (rerr) begin
                            dp_kind = DP_ER;
                            dp_age  = 0;
                        end else begin
                            dp_cap     = 1'b1;
                            exp_hrdata = ref_rd(dp_addr);
                        end
                    end
                    DP_ER: dp_age = 1;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) begin
                ahb_ready = ($urandom_range(0, 3) != 0);
                ahb_resp  = ($urandom_range(0, 15) == 0);
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ctrl_mem[a] = d;
        ref_mem[a]  = d;
    endtask

    task automatic set_idle();
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
    endtask

    // Presents an address phase, holds it until HREADY accepts it, then drives
    // this transfer's write data for its data phase. Returns 1 time unit after
    // the accepting edge.
    task automatic issue(input bit sel, input logic [1:0] tr, input bit wr,
                         input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        bit rdy;
        int n;
        bus.hsel   = sel;
        bus.htrans = tr;
        bus.hwrite = wr;
        bus.haddr  = a;
        bus.hsize  = sz;
        n = 0;
        do begin
            @(negedge clk);
            rdy = bus.hreadyout;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 64);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: hreadyout stuck at %b, required 1 within 64 cycles", rdy);
        end
        bus.hwdata = wr ? wd : $urandom;
    endtask

    initial begin
        int w0;
        rstn        = 1'b1;
        bus.hsel    = 1'b0;
        bus.haddr   = 32'h0;
        bus.htrans  = 2'b00;
        bus.hwrite  = 1'b0;
        bus.hsize   = 3'b010;
        bus.hwdata  = 32'hA5A5_0001;
        ahb_ready   = 1'b1;
        ahb_resp    = 1'b0;
        preload(32'h4000_0008, 32'h1234_5678);
        preload(32'h4000_4004, 32'hCAFE_0004);
        preload(32'h4000_6000, 32'h6666_0000);
        preload(32'h4000_0020, 32'h2020_2020);

        // Reset values
        #2 rstn = 1'b0;
        @(negedge clk);
        #1;
        chk1 ("rst_hreadyout", bus.hreadyout, 1'b1);
        chk1 ("rst_hresp",     bus.hresp,     1'b0);
        chk32("rst_hrdata",    bus.hrdata,    32'h0);
        chk1 ("rst_ahb_we",    ahb_we,        1'b0);
        chk32("rst_ahb_addr",  ahb_addr,      32'h0);
        chk32("rst_passthru",  ahb_write_data, 32'hA5A5_0001);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single write, zero wait states
        issue(1'b1, 2'b10, 1'b1, 32'h4000_2004, 3'b010, 32'hDEAD_BEEF);
        set_idle();
        chk1 ("wr_we",        ahb_we,         1'b1);
        chk32("wr_addr",      ahb_addr,       32'h4000_2004);
        chk32("wr_data",      ahb_write_data, 32'hDEAD_BEEF);
        chk1 ("wr_hreadyout", bus.hreadyout,  1'b1);
        @(posedge clk);
        #1;
        chk1 ("wr_we_single", ahb_we, 1'b0);

        // Single read, one wait state
        issue(1'b1, 2'b10, 1'b0, 32'h4000_0008, 3'b010, 32'h0);
        set_idle();
        chk1 ("rd_wait_hreadyout", bus.hreadyout, 1'b0);
        @(posedge clk);
        #1;
        chk1 ("rd_done_hreadyout", bus.hreadyout, 1'b1);
        chk32("rd_hrdata",         bus.hrdata,    32'h1234_5678);

        // Pipelined write then read
        w0 = we_cnt;
        issue(1'b1, 2'b10, 1'b1, 32'h4000_8004, 3'b010, 32'h0000_0001);
        chk1 ("pipe_we",      ahb_we,   1'b1);
        chk32("pipe_wr_addr", ahb_addr, 32'h4000_8004);
        issue(1'b1, 2'b10, 1'b0, 32'h4000_4004, 3'b010, 32'h0);
        set_idle();
        chk32("pipe_rd_addr", ahb_addr,      32'h4000_4004);
        chk1 ("pipe_rd_wait", bus.hreadyout, 1'b0);
        @(posedge clk);
        #1;
        chk1 ("pipe_rd_done", bus.hreadyout, 1'b1);
        chk32("pipe_hrdata",  bus.hrdata,    32'hCAFE_0004);
        chk32("pipe_we_count", 32'(we_cnt - w0), 32'd1);

        // Write stalled by ahb_ready for 3 cycles
        w0 = we_cnt;
        issue(1'b1, 2'b10, 1'b1, 32'h4000_0010, 3'b010, 32'h55AA_55AA);
        set_idle();
        ahb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("stall_hreadyout", bus.hreadyout, 1'b0);
            chk1("stall_we",        ahb_we,        1'b0);
            @(posedge clk);
            #1;
        end
        ahb_ready = 1'b1;
        #1;
        chk1 ("stall_release_we", ahb_we,        1'b1);
        chk1 ("stall_release_hro", bus.hreadyout, 1'b1);
        @(posedge clk);
        #1;
        chk32("stall_we_count", 32'(we_cnt - w0), 32'd1);

        // Out-of-window read and byte-sized read
        for (int t = 0; t < 2; t++) begin
            w0 = we_cnt;
            if (t == 0) issue(1'b1, 2'b10, 1'b0, 32'h4000_6000, 3'b010, 32'h0);
            else        issue(1'b1, 2'b10, 1'b0, 32'h4000_6000, 3'b000, 32'h0);
            set_idle();
            chk1("odd_first_hro", bus.hreadyout, 1'b0);
            chk1("odd_first_hresp", bus.hresp, ERR_EN);
            @(posedge clk);
            #1;
            chk1("odd_second_hro", bus.hreadyout, 1'b1);
            chk1("odd_second_hresp", bus.hresp, ERR_EN);
            if (!ERR_EN) chk32("odd_okay_hrdata", bus.hrdata, 32'h6666_0000);
            chk32("odd_we_count", 32'(we_cnt - w0), 32'd0);
            @(posedge clk);
            #1;
            chk1("odd_after_hresp", bus.hresp, 1'b0);
        end

        // Reset during a write data phase drops the write
        issue(1'b1, 2'b10, 1'b1, 32'h4000_0020, 3'b010, 32'h7777_7777);
        set_idle();
        chk1("midrst_we_before", ahb_we, 1'b1);
        rstn = 1'b0;
        #1;
        chk1 ("midrst_we",        ahb_we,        1'b0);
        chk1 ("midrst_hreadyout", bus.hreadyout, 1'b1);
        chk32("midrst_addr",      ahb_addr,      32'h0);
        @(posedge clk);
        #1 rstn = 1'b1;
        issue(1'b1, 2'b10, 1'b0, 32'h4000_0020, 3'b010, 32'h0);
        set_idle();
        @(posedge clk);
        #1;
        chk32("midrst_dropped", bus.hrdata, 32'h2020_2020);

        // Randomized traffic against the model
        rand_ready = 1'b1;
        for (int n = 0; n < 800; n++) begin
            int          kind;
            logic [31:0] a;
            logic [2:0]  sz;
            logic [1:0]  tr;
            bit          sel;
            bit          wr;
            kind = $urandom_range(0, 9);
            sel  = ($urandom_range(0, 7) != 0);
            tr   = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b01 : (kind < 6) ? 2'b10 : 2'b11;
            wr   = ($urandom_range(0, 1) == 1);
            a    = ADDR_TAB[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            sz   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            issue(sel, tr, wr, a, sz, $urandom);
        end
        rand_ready = 1'b0;
        ahb_ready  = 1'b1;
        ahb_resp   = 1'b0;
        set_idle();
        repeat (4) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
